// File: rtl/request_unit.sv
// request_unit: memory request sequencer for the single-cycle datapath.
// Turns the decoded load/store/halt of the current instruction plus the
// instruction/data hits into request lines, a PC-advance pulse and a
// sticky halt.
// Optional build macro REQ_PERF_EN adds retired-instruction and
// data-stall counters (instr_count, stall_count).
module request_unit #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dREN,
    input  logic             dWEN,
    input  logic             halt_in,
    output logic             imemREN,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic             pc_en,
    output logic             halt
`ifdef REQ_PERF_EN
    ,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] stall_count
`endif
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DATA  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t state;

    // Fetch stays requested except once halted; retire on ihit for a plain
    // instruction, or on dhit once the data access completes.
    always_comb begin
        imemREN = (state != HALT);
        pc_en   = 1'b0;
        case (state)
            FETCH:   pc_en = ihit & ~halt_in & ~dREN & ~dWEN;
            DATA:    pc_en = dhit;
            default: pc_en = 1'b0;
        endcase
    end

    // Sequencer: captures the data request on entry to DATA and holds it
    // until dhit; HALT absorbs everything until reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= FETCH;
            dmemREN <= 1'b0;
            dmemWEN <= 1'b0;
            halt    <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (ihit) begin
                        if (halt_in) begin
                            state <= HALT;
                            halt  <= 1'b1;
                        end else if (dREN | dWEN) begin
                            state   <= DATA;
                            dmemREN <= dREN;
                            dmemWEN <= dWEN;
                        end
                    end
                end
                DATA: begin
                    if (dhit) begin
                        state   <= FETCH;
                        dmemREN <= 1'b0;
                        dmemWEN <= 1'b0;
                    end
                end
                HALT: begin
                    halt <= 1'b1;
                end
                default: begin
                    state   <= FETCH;
                    dmemREN <= 1'b0;
                    dmemWEN <= 1'b0;
                    halt    <= 1'b0;
                end
            endcase
        end
    end

`ifdef REQ_PERF_EN
    // Performance counters: count retires and DATA cycles; both naturally
    // freeze in HALT since neither event can occur there.
    always_ff @(posedge CLK) begin
        if (RST) begin
            instr_count <= '0;
            stall_count <= '0;
        end else begin
            if (pc_en) begin
                instr_count <= instr_count + CNT_W'(1);
            end
            if (state == DATA) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_request_unit.sv
// Scoreboard bench for request_unit: a stimulus process drives inputs and
// pushes the reference model's expected outputs; a monitor pops and compares
// on the falling edge.
module tb_request_unit;

    localparam int CNT_W = 32;

    logic CLK = 1'b0;
    logic RST, ihit, dhit, dREN, dWEN, halt_in;
    logic imemREN, dmemREN, dmemWEN, pc_en, halt;
`ifdef REQ_PERF_EN
    logic [CNT_W-1:0] instr_count, stall_count;
`endif

    request_unit #(.CNT_W(CNT_W)) dut (
        .CLK(CLK),
        .RST(RST),
        .ihit(ihit),
        .dhit(dhit),
        .dREN(dREN),
        .dWEN(dWEN),
        .halt_in(halt_in),
        .imemREN(imemREN),
        .dmemREN(dmemREN),
        .dmemWEN(dmemWEN),
        .pc_en(pc_en),
        .halt(halt)
`ifdef REQ_PERF_EN
        ,
        .instr_count(instr_count),
        .stall_count(stall_count)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        imem;
        logic        drd;
        logic        dwr;
        logic        pc;
        logic        hlt;
        logic [31:0] icnt;
        logic [31:0] scnt;
    } exp_t;

    exp_t sb_q[$];

    int compared   = 0;
    int mismatched = 0;
    bit done       = 0;

    // Reference model: the processor's view of the current instruction.
    bit          m_halted;
    bit          m_waiting_mem;   // load/store issued, waiting for data
    bit          m_rd, m_wr;
    logic [31:0] m_retired;
    logic [31:0] m_stalls;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // One clock of stimulus: drive inputs, predict outputs, advance model.
    task automatic cyc(input bit r, input bit ih, input bit dh, input bit rd,
                       input bit wr, input bit hi, input bit record);
        exp_t e;
        bit   retires;
        @(posedge CLK);
        #1;
        RST = r; ihit = ih; dhit = dh; dREN = rd; dWEN = wr; halt_in = hi;
        // A plain instruction retires on its fetch; a memory one on its data hit.
        if (m_halted)           retires = 0;
        else if (m_waiting_mem) retires = dh;
        else                    retires = ih && !hi && !rd && !wr;
        e.imem = !m_halted;
        e.drd  = m_rd;
        e.dwr  = m_wr;
        e.pc   = retires;
        e.hlt  = m_halted;
        e.icnt = m_retired;
        e.scnt = m_stalls;
        if (record) sb_q.push_back(e);
        if (r) begin
            m_halted = 0; m_waiting_mem = 0; m_rd = 0; m_wr = 0;
            m_retired = 0; m_stalls = 0;
        end else if (!m_halted) begin
            if (retires) m_retired = m_retired + 1;
            if (m_waiting_mem) begin
                m_stalls = m_stalls + 1;
                if (dh) begin
                    m_waiting_mem = 0; m_rd = 0; m_wr = 0;
                end
            end else if (ih && hi) begin
                m_halted = 1;
            end else if (ih && (rd || wr)) begin
                m_waiting_mem = 1; m_rd = rd; m_wr = wr;
            end
        end
    endtask

    // Monitor: every falling edge with a pending prediction is compared.
    always @(negedge CLK) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("imemREN", {31'b0, imemREN}, {31'b0, e.imem});
            chk("dmemREN", {31'b0, dmemREN}, {31'b0, e.drd});
            chk("dmemWEN", {31'b0, dmemWEN}, {31'b0, e.dwr});
            chk("pc_en",   {31'b0, pc_en},   {31'b0, e.pc});
            chk("halt",    {31'b0, halt},    {31'b0, e.hlt});
`ifdef REQ_PERF_EN
            chk("instr_count", instr_count, e.icnt);
            chk("stall_count", stall_count, e.scnt);
`endif
        end
    end

    initial begin
        #2_000_000;
        if (!done) begin
            $display("FAIL watchdog: bench did not complete, expected finish");
            $fatal(1, "timeout");
        end
    end

    initial begin
        RST = 1; ihit = 0; dhit = 0; dREN = 0; dWEN = 0; halt_in = 0;
        // Two reset cycles; DUT state is unknown before the first edge.
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        // Idle after reset.
        cyc(0, 0, 0, 0, 0, 0, 1);
        // Three plain instructions back to back.
        repeat (3) cyc(0, 1, 0, 0, 0, 0, 1);
        // Load with dhit withheld two cycles.
        cyc(0, 1, 0, 1, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 1, 1, 1);   // decode noise while waiting: ignored
        cyc(0, 0, 1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        // Store, then ihit and dhit together in DATA.
        cyc(0, 1, 0, 0, 1, 0, 1);
        cyc(0, 1, 1, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 0, 1);   // dhit in FETCH ignored
        // Reset while a load is outstanding.
        cyc(0, 1, 0, 1, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        // Illegal load+store decode.
        cyc(0, 1, 0, 1, 1, 0, 1);
        cyc(0, 0, 1, 0, 0, 0, 1);
        // Halt beats a store decode; stays halted despite ihit.
        cyc(0, 1, 0, 0, 1, 1, 1);
        repeat (10) cyc(0, 1, 1, 1, 1, 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 1);
        // Randomized traffic with occasional halts and resets.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) < 2),
                ($urandom_range(0, 99) < 70),
                ($urandom_range(0, 99) < 40),
                ($urandom_range(0, 99) < 25),
                ($urandom_range(0, 99) < 20),
                ($urandom_range(0, 99) < 3),
                1);
        end
        @(posedge CLK);
        @(negedge CLK);
        #1;
        compared++;
        if (sb_q.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", sb_q.size());
        end
        done = 1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/request_unit.md
Name: request_unit

Overview:
- Sequences memory requests for the single-cycle datapath.
- Consumes the control unit's decoded dREN/dWEN/halt and the memory hits (ihit, dhit).
- Drives the cache/memory request lines (imemREN, dmemREN, dmemWEN), the PC-advance enable and the latched CPU halt.
- Sits between the control unit outputs and the memory-side interface; it is the response side of the ihit/dhit → control handshake.

Parameters:
- CNT_W, 32, width of the optional performance counters.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous active-high reset.
- ihit  input  1  instruction-memory hit for the current fetch.
- dhit  input  1  data-memory hit for the outstanding data request.
- dREN  input  1  control-unit decode: current instruction is a load.
- dWEN  input  1  control-unit decode: current instruction is a store.
- halt_in  input  1  control-unit decode: current instruction is HALT.
- imemREN  output  1  instruction read request.
- dmemREN  output  1  data read request, registered.
- dmemWEN  output  1  data write request, registered.
- pc_en  output  1  one-cycle pulse: current instruction retires; PC and register file may commit.
- halt  output  1  sticky CPU halt, registered.
- instr_count  output  CNT_W  retired-instruction count (REQ_PERF_EN only).
- stall_count  output  CNT_W  cycles spent in DATA (REQ_PERF_EN only).

Behaviour:
- Reset: RST sampled on rising CLK, synchronous, active-high. Fixed.
- Reset values: state=FETCH, dmemREN=0, dmemWEN=0, halt=0, counters=0.
- imemREN is combinational: 1 in FETCH and DATA, 0 in HALT. It stays high during DATA; the memory controller arbitrates data before instruction.
- FETCH:
  - ihit=0 → stay; pc_en=0.
  - ihit=1 & halt_in=1 → HALT next cycle; pc_en=0. halt_in has priority over dREN/dWEN.
  - ihit=1 & (dREN|dWEN) → DATA next cycle; dmemREN<=dREN, dmemWEN<=dWEN; pc_en=0.
  - ihit=1 & no data & no halt → stay; pc_en=1 in the same cycle (combinational).
  - dhit in FETCH is ignored.
- DATA:
  - dmemREN/dmemWEN are held unchanged.
  - dhit=0 → stay.
  - dhit=1 → pc_en=1 (combinational); next cycle state=FETCH and dmemREN=dmemWEN=0.
  - ihit in DATA is ignored, including when ihit and dhit are asserted together.
- Decode inputs changing while in DATA have no effect; the request was captured on entry.
- dREN=dWEN=1 together is illegal decode: both request lines are asserted, with no checking.
- HALT:
  - imemREN, dmemREN, dmemWEN, pc_en are all 0; halt=1.
  - Absorbing: only RST exits.
- Reset mid-operation: RST in DATA drops dmemREN/dmemWEN on the next edge, with no dhit wait.
- Latency:
  - Non-memory instruction retires in the ihit cycle.
  - Load/store retires in the dhit cycle, minimum 1 cycle after ihit.
- pc_en is never asserted in two consecutive cycles for one instruction.

Optional Feature:
- Macro: REQ_PERF_EN.
- Defined:
  - instr_count increments on every pc_en.
  - stall_count increments on every cycle state==DATA.
  - Both wrap modulo 2^CNT_W, freeze in HALT, and clear on RST.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- RST=1 for 2 cycles, then release with ihit=0 → imemREN=1, dmemREN=dmemWEN=pc_en=halt=0.
- ihit=1, dREN=dWEN=halt_in=0 for 3 cycles → pc_en=1 each cycle, dmemREN=0; REQ_PERF_EN: instr_count=3.
- Load:
  - Stimulus: ihit=1 with dREN=1, dhit withheld 2 cycles, then dhit=1.
  - Required: dmemREN=1 from cycle+1 through the dhit cycle; pc_en=1 only in the dhit cycle; dmemREN=0 the cycle after.
  - REQ_PERF_EN: stall_count=3.
- Store with ihit and dhit asserted together in DATA → single pc_en pulse, dmemWEN cleared the next cycle, no extra retire.
- ihit=1 with halt_in=1 and dWEN=1 → halt=1 next cycle, dmemWEN stays 0, imemREN=0; remains halted 10 cycles despite ihit.
- RST asserted in DATA with dmemREN=1 → next cycle dmemREN=0, state FETCH, counters 0.
